// File: rtl/regbank_writeback.sv
// Register-bank write-port owner: merges ALU results with in-order load returns and flags read hazards.
// Optional statistics (conflict_cnt, max_occ) are built when WB_STATS_EN is defined.
module regbank_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_we,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              issue_ready,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] chk_a,
    input  logic [ADDR_W-1:0] chk_b,
    output logic              stall,
    output logic              we,
    output logic [ADDR_W-1:0] addr_d,
    output logic [DATA_W-1:0] data_d,
    output logic              err
`ifdef WB_STATS_EN
    ,
    output logic [15:0]            conflict_cnt,
    output logic [$clog2(DEPTH):0] max_occ
`endif
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << ADDR_W;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  q_valid, q_filled;
    logic [PW-1:0]     head, fill, tail;
    logic [CW-1:0]     count, unfilled, discard;
    logic [CW-1:0]     count_nxt, discard_nxt;
    logic [NREG-1:0]   pending;
    logic              alu_wr, head_ready, ld_live, discard_dec;
    logic              do_issue, do_fill, do_pop, fill_err, waw_err;

    // Handshake: a load is accepted on an edge where ld_issue && issue_ready;
    // issue_ready uses pre-edge occupancy, so a same-cycle drain frees no slot.
    assign issue_ready = (count < CW'(DEPTH)) && (discard == '0);

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i]) pending[q_addr[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign stall = pending[chk_a] || pending[chk_b];

    assign alu_wr      = alu_we && (alu_addr != '0);
    assign head_ready  = q_valid[head] && q_filled[head];
    assign do_issue    = ld_issue && issue_ready && !flush;
    assign ld_live     = ld_valid && (discard == '0);
    assign discard_dec = ld_valid && (discard != '0);
    assign do_fill     = ld_live && (unfilled != '0);
    assign fill_err    = ld_live && (unfilled == '0);
    assign do_pop      = !flush && !alu_wr && head_ready;
    assign waw_err     = !flush && alu_wr && pending[alu_addr];

    always_comb begin
        count_nxt   = count + CW'(do_issue) - CW'(do_pop);
        discard_nxt = discard - CW'(discard_dec);
        if (flush) begin
            count_nxt = '0;
            // a return landing on the flush edge is already accounted for
            discard_nxt = discard_nxt + unfilled - CW'(do_fill);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
            q_valid  <= '0;
            q_filled <= '0;
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            count    <= '0;
            unfilled <= '0;
            discard  <= '0;
            we       <= 1'b0;
            addr_d   <= '0;
            data_d   <= '0;
            err      <= 1'b0;
        end else begin
            count   <= count_nxt;
            discard <= discard_nxt;
            err     <= err | fill_err | waw_err;
            if (flush) begin
                q_valid  <= '0;
                q_filled <= '0;
                head     <= '0;
                fill     <= '0;
                tail     <= '0;
                unfilled <= '0;
                we       <= 1'b0;
            end else begin
                // issue, fill and pop always address distinct entries
                if (do_issue) begin
                    q_addr[tail]   <= ld_addr;
                    q_valid[tail]  <= 1'b1;
                    q_filled[tail] <= 1'b0;
                    tail           <= tail + 1'b1;
                end
                if (do_fill) begin
                    q_data[fill]   <= ld_data;
                    q_filled[fill] <= 1'b1;
                    fill           <= fill + 1'b1;
                end
                if (do_pop) begin
                    q_valid[head]  <= 1'b0;
                    q_filled[head] <= 1'b0;
                    head           <= head + 1'b1;
                end
                unfilled <= unfilled + CW'(do_issue) - CW'(do_fill);

                if (alu_wr) begin
                    we     <= 1'b1;
                    addr_d <= alu_addr;
                    data_d <= alu_data;
                end else if (do_pop && (q_addr[head] != '0)) begin
                    we     <= 1'b1;
                    addr_d <= q_addr[head];
                    data_d <= q_data[head];
                end else begin
                    we <= 1'b0;
                end
            end
        end
    end

`ifdef WB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_cnt <= '0;
            max_occ      <= '0;
        end else begin
            if (!flush && alu_wr && head_ready && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
            if (count_nxt > max_occ) max_occ <= count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_regbank_writeback.sv
// Randomized and directed bench for regbank_writeback against a queue-based behavioural model.
module tb_regbank_writeback;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_we, ld_issue, ld_valid, flush;
    logic [AW-1:0] alu_addr, ld_addr, chk_a, chk_b;
    logic [DW-1:0] alu_data, ld_data;
    logic          issue_ready, stall, we, err;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] data_d;
`ifdef WB_STATS_EN
    logic [15:0]   conflict_cnt;
    logic [2:0]    max_occ;
`endif

    always #5 clk = ~clk;

    regbank_writeback #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_addr(ld_addr), .issue_ready(issue_ready),
        .ld_valid(ld_valid), .ld_data(ld_data), .flush(flush),
        .chk_a(chk_a), .chk_b(chk_b), .stall(stall),
        .we(we), .addr_d(addr_d), .data_d(data_d), .err(err)
`ifdef WB_STATS_EN
        , .conflict_cnt(conflict_cnt), .max_occ(max_occ)
`endif
    );

    // behavioural model: the outstanding loads in issue order
    typedef struct {
        logic [AW-1:0] addr;
        bit            filled;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    int            m_discard;
    bit            m_err, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            m_conf, m_maxocc;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_pending(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_ready();
        return (mq.size() < DEPTH) && (m_discard == 0);
    endfunction

    function automatic int m_unfilled();
        int n = 0;
        foreach (mq[i]) if (!mq[i].filled) n++;
        return n;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_discard = 0;
        m_err     = 1'b0;
        e_we      = 1'b0;
        e_addr    = '0;
        e_data    = '0;
        m_conf    = 0;
        m_maxocc  = 0;
    endtask

    task automatic model_edge();
        int first = -1;
        int unf   = 0;
        bit dec, live, got, head_f, alu_wr, rdy;
        foreach (mq[i]) begin
            if (!mq[i].filled) begin
                if (first < 0) first = i;
                unf++;
            end
        end
        dec  = ld_valid && (m_discard > 0);
        live = ld_valid && (m_discard == 0);
        got  = live && (first >= 0);
        rdy  = m_ready();
        if (live && !got) m_err = 1'b1;
        if (flush) begin
            m_discard = m_discard - int'(dec) + unf - int'(got);
            mq.delete();
            e_we = 1'b0;
        end else begin
            head_f = (mq.size() > 0) && mq[0].filled;
            alu_wr = alu_we && (alu_addr != 0);
            if (alu_wr && m_pending(alu_addr)) m_err = 1'b1;
            if (dec) m_discard--;
            if (got) begin
                mq[first].filled = 1'b1;
                mq[first].data   = ld_data;
            end
            if (alu_wr) begin
                e_we   = 1'b1;
                e_addr = alu_addr;
                e_data = alu_data;
                if (head_f && m_conf < 65535) m_conf++;
            end else if (head_f) begin
                ent_t e;
                e    = mq.pop_front();
                e_we = (e.addr != 0);
                if (e.addr != 0) begin
                    e_addr = e.addr;
                    e_data = e.data;
                end
            end else begin
                e_we = 1'b0;
            end
            if (ld_issue && rdy) mq.push_back('{ld_addr, 1'b0, 32'h0});
        end
        if (mq.size() > m_maxocc) m_maxocc = mq.size();
    endtask

    function automatic bit m_stall();
        return m_pending(chk_a) || m_pending(chk_b);
    endfunction

    // called at a falling edge with inputs already driven; returns at the next falling edge
    task automatic tick();
        #1;
        check("issue_ready", {31'b0, issue_ready}, {31'b0, m_ready()});
        check("stall", {31'b0, stall}, {31'b0, m_stall()});
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("we", {31'b0, we}, {31'b0, e_we});
        check("addr_d", {28'b0, addr_d}, {28'b0, e_addr});
        check("data_d", data_d, e_data);
        check("err", {31'b0, err}, {31'b0, m_err});
`ifdef WB_STATS_EN
        check("conflict_cnt", {16'b0, conflict_cnt}, m_conf);
        check("max_occ", {29'b0, max_occ}, m_maxocc);
`endif
    endtask

    task automatic idle();
        alu_we = 0; alu_addr = 0; alu_data = 0;
        ld_issue = 0; ld_addr = 0; ld_valid = 0; ld_data = 0;
        flush = 0; chk_a = 0; chk_b = 0;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        idle(); ld_issue = 1; ld_addr = a; tick();
    endtask

    task automatic ret(input logic [DW-1:0] d);
        idle(); ld_valid = 1; ld_data = d; tick();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_we", {31'b0, we}, 0);
        check("rst_addr_d", {28'b0, addr_d}, 0);
        check("rst_data_d", data_d, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_issue_ready", {31'b0, issue_ready}, 1);
        check("rst_stall", {31'b0, stall}, 0);
        reset = 1'b1;

        // ALU path
        idle(); alu_we = 1; alu_addr = 3; alu_data = 32'h1234; tick();
        check("alu_we", {31'b0, we}, 1);
        check("alu_addr", {28'b0, addr_d}, 3);
        check("alu_data", data_d, 32'h1234);
        idle(); alu_we = 1; alu_addr = 0; alu_data = 32'h5555; tick();
        check("alu_r0", {31'b0, we}, 0);

        // load ordering with a stall on r5
        issue(5);
        issue(6);
        idle(); chk_a = 5; ld_valid = 1; ld_data = 32'hA; tick();
        idle(); chk_a = 5; ld_valid = 1; ld_data = 32'hB; tick();
        repeat (3) begin idle(); chk_a = 5; tick(); end

        // ALU priority over a filled head
        issue(7);
        ret(32'h77);
        repeat (3) begin idle(); alu_we = 1; alu_addr = 2; alu_data = 32'h22; tick(); end
`ifdef WB_STATS_EN
        check("conflict_3", {16'b0, conflict_cnt}, 3);
`endif
        repeat (2) begin idle(); tick(); end

        // full queue
        for (int i = 0; i < DEPTH; i++) issue(AW'(8 + i));
        idle(); ld_issue = 1; ld_addr = 12;
        #1 check("full_ready", {31'b0, issue_ready}, 0);
        tick();
        ret(32'h80);
        idle(); tick();
        check("drain_ready", {31'b0, issue_ready}, 1);
        for (int i = 0; i < 3; i++) ret(32'h81 + i);
        repeat (4) begin idle(); tick(); end

        // flush with two filled and two unfilled entries
        for (int i = 1; i <= 4; i++) issue(AW'(i));
        for (int i = 0; i < 2; i++) begin
            idle(); ld_valid = 1; ld_data = 32'hF0 + i; alu_we = 1; alu_addr = 9; alu_data = 32'h99; tick();
        end
        idle(); flush = 1; ld_issue = 1; ld_addr = 3; chk_a = 1; tick();
        idle(); chk_a = 1; chk_b = 2; tick();
        ret(32'hD0);
        ret(32'hD1);
        idle(); tick();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            idle();
            flush    = ($urandom_range(0, 39) == 0);
            ld_issue = $urandom_range(0, 1);
            ld_addr  = AW'($urandom_range(0, 15));
            ld_valid = !flush && ($urandom_range(0, 1) == 1) && (m_unfilled() > 0 || m_discard > 0);
            ld_data  = $urandom;
            alu_addr = AW'($urandom_range(0, 15));
            alu_we   = ($urandom_range(0, 2) == 0) && !m_pending(alu_addr);
            alu_data = $urandom;
            chk_a    = AW'($urandom_range(0, 15));
            chk_b    = AW'($urandom_range(0, 15));
            tick();
        end

        // settle, then error cases
        idle(); flush = 1; tick();
        for (int k = 0; k < 2 * DEPTH && m_discard > 0; k++) ret(32'hEE);
        idle(); tick();
        check("pre_err", {31'b0, err}, 0);
        ret(32'hBAD);
        check("err_empty", {31'b0, err}, 1);
        issue(4);
        idle(); alu_we = 1; alu_addr = 4; alu_data = 32'h44; tick();
        check("waw_we", {31'b0, we}, 1);
        check("waw_addr", {28'b0, addr_d}, 4);
        check("waw_data", data_d, 32'h44);
        ret(32'h4444);
        repeat (3) begin idle(); tick(); end
        check("err_hold", {31'b0, err}, 1);

        // reset mid-operation, then a late return
        issue(6);
        idle(); chk_a = 6;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_err", {31'b0, err}, 0);
        check("mid_rst_we", {31'b0, we}, 0);
        check("mid_rst_stall", {31'b0, stall}, 0);
        check("mid_rst_ready", {31'b0, issue_ready}, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        ret(32'h66);
        check("late_ret_err", {31'b0, err}, 1);
        idle(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
